// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the arbiter state type used by the bus arbiter,
// its interface and the data-phase muxes.
package ahb_pkg;

    localparam int AHB_TRANS_BITS = 2;
    localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_IDLE   = 2'b00;
    localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_BUSY   = 2'b01;
    localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_NONSEQ = 2'b10;
    localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_SEQ    = 2'b11;

    localparam int AHB_RESP_BITS = 2;
    localparam logic [AHB_RESP_BITS-1:0] AHB_RESP_OKAY  = 2'b00;
    localparam logic [AHB_RESP_BITS-1:0] AHB_RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWN    = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signals between the masters/bus muxes and the AHB arbiter.
// The master modport is the arbiter's view: it drives grant and ownership.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    import ahb_pkg::*;

    localparam int MIDX_BITS = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]    HBUSREQ;
    logic [NUM_MASTERS-1:0]    HLOCK;
    logic [AHB_TRANS_BITS-1:0] HTRANS;
    logic                      HREADY;
    logic [NUM_MASTERS-1:0]    HGRANT;
    logic [MIDX_BITS-1:0]      HMASTER;
    logic                      HMASTLOCK;

    modport master (
        input  HBUSREQ,
        input  HLOCK,
        input  HTRANS,
        input  HREADY,
        output HGRANT,
        output HMASTER,
        output HMASTLOCK
    );

    modport slave (
        output HBUSREQ,
        output HLOCK,
        output HTRANS,
        output HREADY,
        input  HGRANT,
        input  HMASTER,
        input  HMASTLOCK
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after i_ptr, wrapping,
// with i_ptr itself searched last so a sole requester keeps its slot.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic                 o_valid,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] w_cand;

    // Walk from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_ptr;
        w_cand  = '0;
        for (int k = N; k >= 1; k--) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: registered one-hot grant, HMASTER/HMASTLOCK address
// pipeline, lock and burst holding, parking on DEFAULT_MASTER when idle.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_bus_arbiter_if.master  bus,
    output logic [1:0]         o_state
);
    localparam int MIDX_BITS = $clog2(NUM_MASTERS);

    localparam logic [1:0] ST_PARK   = ARB_PARK;
    localparam logic [1:0] ST_OWN    = ARB_OWN;
    localparam logic [1:0] ST_LOCKED = ARB_LOCKED;

    localparam logic [MIDX_BITS-1:0]   DEF_IDX   = MIDX_BITS'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] r_grant;
    logic [MIDX_BITS-1:0]   r_ptr;
    logic [1:0]             r_state;
    logic [MIDX_BITS-1:0]   r_hmaster;
    logic                   r_hmastlock;

    logic [MIDX_BITS-1:0]   w_gidx;
    logic                   w_owner_lock;
    logic                   w_hold;
    logic                   w_arb;
    logic                   w_pick_valid;
    logic [MIDX_BITS-1:0]   w_pick_idx;
    logic [MIDX_BITS-1:0]   w_win_idx;
    logic                   w_win_lock;
    logic [NUM_MASTERS-1:0] w_win_onehot;
    logic [1:0]             w_arb_state;
    logic [1:0]             w_next_state;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) w_gidx = MIDX_BITS'(i);
        end
    end

    // SEQ/BUSY keep a burst on the bus; handover waits for the next IDLE/NONSEQ.
    assign w_owner_lock = bus.HLOCK[w_gidx];
    assign w_hold       = w_owner_lock
                        | (bus.HTRANS == AHB_TRANS_SEQ)
                        | (bus.HTRANS == AHB_TRANS_BUSY);
    assign w_arb        = bus.HREADY & ~w_hold;

    rr_picker #(
        .N (NUM_MASTERS)
    ) u_rr_picker (
        .i_req   (bus.HBUSREQ),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_win_idx    = w_pick_valid ? w_pick_idx : DEF_IDX;
    assign w_win_lock   = bus.HLOCK[w_win_idx];
    assign w_win_onehot = NUM_MASTERS'(1) << w_win_idx;
    assign w_arb_state  = !w_pick_valid ? ST_PARK :
                          (w_win_lock ? ST_LOCKED : ST_OWN);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_PARK: begin
                if (w_arb) w_next_state = w_arb_state;
            end
            ST_OWN: begin
                // A lock raised by the owner freezes arbitration via hold.
                if (w_arb) w_next_state = w_arb_state;
                else if (bus.HREADY && w_owner_lock) w_next_state = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_arb) w_next_state = w_arb_state;
            end
            default: w_next_state = ST_PARK;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_grant     <= DEF_GRANT;
            r_ptr       <= DEF_IDX;
            r_state     <= ST_PARK;
            r_hmaster   <= DEF_IDX;
            r_hmastlock <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_arb) begin
                r_grant <= w_win_onehot;
                if (w_pick_valid) r_ptr <= w_pick_idx;
            end
            if (bus.HREADY) begin
                r_hmaster   <= w_gidx;
                r_hmastlock <= w_owner_lock;
            end
        end
    end

    assign bus.HGRANT    = r_grant;
    assign bus.HMASTER   = r_hmaster;
    assign bus.HMASTLOCK = r_hmastlock;
    assign o_state       = r_state;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scenario bench for ahb_bus_arbiter (4 masters, default master 0): expected
// {HGRANT,HMASTER,HMASTLOCK,state} words are queued at drive time, popped after each edge.
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [1:0] state;

    ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus),
        .o_state (state)
    );

    always #5 HCLK = ~HCLK;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    localparam logic [1:0] S_PARK = ARB_PARK;
    localparam logic [1:0] S_OWN  = ARB_OWN;
    localparam logic [1:0] S_LOCK = ARB_LOCKED;

    function automatic logic [8:0] pk(input logic [3:0] g, input int m, input logic l,
                                      input logic [1:0] s);
        return {g, 2'(m), l, s};
    endfunction

    task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                         input logic rdy, input logic [8:0] exp);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = trans;
        bus.HREADY  = rdy;
        exp_q.push_back(exp);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_reset();
        HRESETn     = 1'b0;
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = AHB_TRANS_IDLE;
        bus.HREADY  = 1'b1;
        step();
        step();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] exp, got;
        HRESETn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) HRESETn = 1'b1;
            case (i)
                0, 1, 2: drive(4'b0110, 4'b0000, AHB_TRANS_IDLE, 1'b1, pk(4'b0001, 0, 1'b0, S_PARK));
                3:       drive(4'b0110, 4'b0000, AHB_TRANS_IDLE, 1'b1, pk(4'b0010, 0, 1'b0, S_OWN));
                default: drive(4'b0110, 4'b0000, AHB_TRANS_IDLE, 1'b1, pk(4'b0100, 1, 1'b0, S_OWN));
            endcase
            step();
            exp = exp_q.pop_front();
            got = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, state};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset cyc %0d: got %b required %b (grant,hmaster,lock,state)", i, got, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [8:0] exp, got;
        logic [8:0] tab [5];
        tab = '{pk(4'b0010, 0, 1'b0, S_OWN), pk(4'b0100, 1, 1'b0, S_OWN),
                pk(4'b1000, 2, 1'b0, S_OWN), pk(4'b0001, 3, 1'b0, S_OWN),
                pk(4'b0010, 0, 1'b0, S_OWN)};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000, AHB_TRANS_NONSEQ, 1'b1, tab[i]);
            step();
            exp = exp_q.pop_front();
            got = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, state};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL round_robin cyc %0d: got %b required %b (grant,hmaster,lock,state)", i, got, exp);
            end
        end
    endtask

    task automatic test_burst();
        logic [8:0] exp, got;
        logic [3:0] req_t [7];
        logic [1:0] trn_t [7];
        logic [8:0] tab   [7];
        req_t = '{4'b0100, 4'b0100, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101};
        trn_t = '{AHB_TRANS_IDLE, AHB_TRANS_NONSEQ, AHB_TRANS_SEQ, AHB_TRANS_SEQ,
                  AHB_TRANS_SEQ, AHB_TRANS_IDLE, AHB_TRANS_NONSEQ};
        tab   = '{pk(4'b0100, 0, 1'b0, S_OWN), pk(4'b0100, 2, 1'b0, S_OWN),
                  pk(4'b0100, 2, 1'b0, S_OWN), pk(4'b0100, 2, 1'b0, S_OWN),
                  pk(4'b0100, 2, 1'b0, S_OWN), pk(4'b1000, 2, 1'b0, S_OWN),
                  pk(4'b0001, 3, 1'b0, S_OWN)};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(req_t[i], 4'b0000, trn_t[i], 1'b1, tab[i]);
            step();
            exp = exp_q.pop_front();
            got = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, state};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL burst cyc %0d: got %b required %b (grant,hmaster,lock,state)", i, got, exp);
            end
        end
    endtask

    task automatic test_lock();
        logic [8:0] exp, got;
        logic [3:0] lck_t [10];
        logic [8:0] tab   [10];
        lck_t = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                  4'b0000, 4'b1000, 4'b1000, 4'b1000};
        tab   = '{pk(4'b0010, 0, 1'b0, S_LOCK), pk(4'b0010, 1, 1'b1, S_LOCK),
                  pk(4'b0010, 1, 1'b1, S_LOCK), pk(4'b0010, 1, 1'b1, S_LOCK),
                  pk(4'b0010, 1, 1'b1, S_LOCK), pk(4'b0010, 1, 1'b1, S_LOCK),
                  pk(4'b0100, 1, 1'b0, S_OWN),  pk(4'b1000, 2, 1'b0, S_LOCK),
                  pk(4'b1000, 3, 1'b1, S_LOCK), pk(4'b0001, 0, 1'b0, S_PARK)};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            // Last cycle: reset lands while master 3 holds a locked sequence.
            if (i == 9) HRESETn = 1'b0;
            drive(4'b1111, lck_t[i], AHB_TRANS_NONSEQ, 1'b1, tab[i]);
            step();
            exp = exp_q.pop_front();
            got = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, state};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lock cyc %0d: got %b required %b (grant,hmaster,lock,state)", i, got, exp);
            end
        end
        HRESETn = 1'b1;
    endtask

    task automatic test_wait_states();
        logic [8:0] exp, got;
        logic [3:0] req_t [6];
        logic       rdy_t [6];
        logic [8:0] tab   [6];
        req_t = '{4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        rdy_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tab   = '{pk(4'b0010, 0, 1'b0, S_OWN), pk(4'b0010, 0, 1'b0, S_OWN),
                  pk(4'b0010, 0, 1'b0, S_OWN), pk(4'b0010, 0, 1'b0, S_OWN),
                  pk(4'b1000, 1, 1'b0, S_OWN), pk(4'b1000, 3, 1'b0, S_OWN)};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(req_t[i], 4'b0000, AHB_TRANS_IDLE, rdy_t[i], tab[i]);
            step();
            exp = exp_q.pop_front();
            got = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, state};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wait_states cyc %0d: got %b required %b (grant,hmaster,lock,state)", i, got, exp);
            end
        end
    endtask

    task automatic test_park();
        logic [8:0] exp, got;
        logic [3:0] req_t [7];
        logic [1:0] trn_t [7];
        logic [8:0] tab   [7];
        req_t = '{4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b1111};
        trn_t = '{AHB_TRANS_NONSEQ, AHB_TRANS_IDLE, AHB_TRANS_IDLE, AHB_TRANS_NONSEQ,
                  AHB_TRANS_IDLE, AHB_TRANS_IDLE, AHB_TRANS_NONSEQ};
        tab   = '{pk(4'b1000, 0, 1'b0, S_OWN),  pk(4'b0001, 3, 1'b0, S_PARK),
                  pk(4'b0001, 0, 1'b0, S_PARK), pk(4'b0001, 0, 1'b0, S_OWN),
                  pk(4'b0100, 0, 1'b0, S_OWN),  pk(4'b0001, 2, 1'b0, S_PARK),
                  pk(4'b1000, 0, 1'b0, S_OWN)};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(req_t[i], 4'b0000, trn_t[i], 1'b1, tab[i]);
            step();
            exp = exp_q.pop_front();
            got = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, state};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL park cyc %0d: got %b required %b (grant,hmaster,lock,state)", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp, got;
        logic [3:0] req;
        logic [1:0] trn;
        logic       rdy, found;
        int         m_g, m_ptr, m_hm, nidx, c;
        logic [1:0] m_st;
        apply_reset();
        m_g = 0; m_ptr = 0; m_hm = 0; m_st = S_PARK;
        for (int i = 0; i < 40; i++) begin
            req = 4'($urandom_range(0, 15));
            trn = ($urandom_range(0, 1) != 0) ? AHB_TRANS_NONSEQ : AHB_TRANS_IDLE;
            rdy = ($urandom_range(0, 3) != 0);
            if (rdy) begin
                found = 1'b0;
                nidx  = 0;
                for (int k = 1; k <= 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        nidx  = c;
                    end
                end
                m_hm = m_g;
                if (found) begin
                    m_g = nidx; m_ptr = nidx; m_st = S_OWN;
                end else begin
                    m_g = 0; m_st = S_PARK;
                end
            end
            drive(req, 4'b0000, trn, rdy, pk(4'(1 << m_g), m_hm, 1'b0, m_st));
            step();
            exp = exp_q.pop_front();
            got = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, state};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc %0d req %b rdy %b: got %b required %b (grant,hmaster,lock,state)",
                         i, req, rdy, got, exp);
            end
        end
    endtask

    initial begin
        HRESETn     = 1'b0;
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = AHB_TRANS_IDLE;
        bus.HREADY  = 1'b1;
        test_reset();
        test_round_robin();
        test_burst();
        test_lock();
        test_wait_states();
        test_park();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
